// File: rtl/nmr_pulse_sequencer.sv
// NMR pulse sequencer: LOAD, then per-scan PULSE/GAP pairs, ACQ window and REPDLY, ending in DONE.
// Optional RF phase cycling across scans is enabled by defining NMR_SEQ_PHASE_CYCLE_EN.
module nmr_pulse_sequencer #(
  parameter int NPULSE = 4,
  parameter int CW     = 32,
  parameter int SW     = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start_i,
  input  logic                         abort_i,
  input  logic [$clog2(NPULSE+1)-1:0]  cfg_npulse_i,
  input  logic [NPULSE*CW-1:0]         cfg_pulse_len_i,
  input  logic [NPULSE*CW-1:0]         cfg_gap_len_i,
  input  logic [NPULSE*16-1:0]         cfg_amp_i,
  input  logic [31:0]                  cfg_freq_i,
  input  logic [CW-1:0]                cfg_acq_len_i,
  input  logic [CW-1:0]                cfg_rep_dly_i,
  input  logic [SW-1:0]                cfg_nscan_i,
  output logic                         en_gen_o,
  output logic [15:0]                  amp_o,
  output logic [31:0]                  freq_o,
  output logic [1:0]                   phase_o,
  output logic                         acq_rst_n_o,
  output logic                         acq_en_o,
  output logic [SW-1:0]                scan_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [5:0]                   leds_o,
  output logic [31:0]                  sts_o
);
  localparam int NPW = $clog2(NPULSE+1);
  localparam int PW  = $clog2(2*NPULSE+1);
  localparam int KW  = (NPULSE > 1) ? $clog2(NPULSE) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_PULSE  = 3'd2;
  localparam logic [2:0] S_GAP    = 3'd3;
  localparam logic [2:0] S_ACQ    = 3'd4;
  localparam logic [2:0] S_REPDLY = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  logic [2:0]     state_reg, state_next;
  logic           start_q_reg;
  logic [PW-1:0]  pos_reg, pos_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic [SW-1:0]  scan_reg, scan_next;
  logic           aborted_reg, aborted_next;
  logic           latch_cfg, scan_adv, do_srch;

  logic [NPW-1:0] npulse_reg;
  logic [31:0]    freq_reg;
  logic [CW-1:0]  acq_len_reg, rep_dly_reg;
  logic [SW-1:0]  nscan_reg;
  logic [CW-1:0]  seg_len [2*NPULSE];
  logic [15:0]    amp_tab [NPULSE];

  logic           en_gen_reg, acq_en_reg, acq_rst_n_reg, busy_reg, done_reg;
  logic [5:0]     leds_reg, leds_next;
  logic [31:0]    sts_reg, sts_next;
  logic [15:0]    amp_reg, amp_next;
  logic           busy_next, done_next;

  // Even sequence positions are pulses, odd positions are the gaps that follow them.
  for (genvar gi = 0; gi < NPULSE; gi++) begin : g_cfg
    logic [CW-1:0] pulse_len_reg, gap_len_reg;
    logic [15:0]   amp_cfg_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pulse_len_reg <= '0;
        gap_len_reg   <= '0;
        amp_cfg_reg   <= '0;
      end else if (latch_cfg) begin
        pulse_len_reg <= cfg_pulse_len_i[gi*CW +: CW];
        gap_len_reg   <= cfg_gap_len_i[gi*CW +: CW];
        amp_cfg_reg   <= cfg_amp_i[gi*16 +: 16];
      end
    end
    assign seg_len[2*gi]   = pulse_len_reg;
    assign seg_len[2*gi+1] = gap_len_reg;
    assign amp_tab[gi]     = amp_cfg_reg;
  end

  logic [CW-1:0] acq_eff;
  logic [SW:0]   nscan_eff, scan_inc;
  assign acq_eff   = (acq_len_reg == '0) ? CW'(1) : acq_len_reg;
  assign nscan_eff = (nscan_reg == '0) ? (SW+1)'(1) : {1'b0, nscan_reg};
  assign scan_inc  = {1'b0, scan_reg} + (SW+1)'(1);

  // Find the next non-empty segment so zero-length pulses/gaps take no cycles.
  logic [PW-1:0] srch_start, srch_pos;
  logic          srch_found;
  always_comb begin
    srch_start = (state_reg == S_PULSE || state_reg == S_GAP) ? pos_reg + PW'(1) : '0;
    srch_found = 1'b0;
    srch_pos   = '0;
    for (int j = 0; j < 2*NPULSE; j++) begin
      if (!srch_found && (j >= int'(srch_start)) && (j < 2*int'(npulse_reg)) &&
          (seg_len[j] != '0)) begin
        srch_found = 1'b1;
        srch_pos   = PW'(j);
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    pos_next     = pos_reg;
    cnt_next     = cnt_reg;
    scan_next    = scan_reg;
    aborted_next = aborted_reg;
    latch_cfg    = 1'b0;
    scan_adv     = 1'b0;
    do_srch      = 1'b0;
    if (abort_i && state_reg != S_IDLE) begin
      state_next   = S_IDLE;
      aborted_next = 1'b1;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start_i && !start_q_reg) begin
            state_next   = S_LOAD;
            latch_cfg    = 1'b1;
            aborted_next = 1'b0;
            pos_next     = '0;
            scan_next    = '0;
            cnt_next     = '0;
          end
        end
        S_LOAD: do_srch = 1'b1;
        S_PULSE, S_GAP, S_REPDLY: begin
          if (cnt_reg == CW'(1)) do_srch = 1'b1;
          else cnt_next = cnt_reg - CW'(1);
        end
        S_ACQ: begin
          if (cnt_reg == CW'(1)) begin
            pos_next = '0;
            if (scan_inc >= nscan_eff) begin
              state_next = S_DONE;
            end else begin
              scan_next = scan_inc[SW-1:0];
              scan_adv  = 1'b1;
              if (rep_dly_reg != '0) begin
                state_next = S_REPDLY;
                cnt_next   = rep_dly_reg;
              end else begin
                do_srch = 1'b1;
              end
            end
          end else begin
            cnt_next = cnt_reg - CW'(1);
          end
        end
        S_DONE:  if (!start_i) state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
      if (do_srch) begin
        if (srch_found) begin
          pos_next   = srch_pos;
          state_next = srch_pos[0] ? S_GAP : S_PULSE;
          cnt_next   = seg_len[srch_pos];
        end else begin
          state_next = S_ACQ;
          cnt_next   = acq_eff;
        end
      end
    end
  end

  logic [KW-1:0] k_next;
  assign k_next    = KW'(pos_next >> 1);
  assign busy_next = (state_next != S_IDLE) && (state_next != S_DONE);
  assign done_next = (state_next == S_DONE);
  assign amp_next  = (state_next == S_PULSE) ? amp_tab[k_next] : 16'd0;
  assign sts_next  = {16'(scan_next), 9'd0, state_next, 1'b0, aborted_next, busy_next, done_next};

  always_comb begin
    leds_next = 6'd0;
    case (state_next)
      S_LOAD:   leds_next = 6'b000001;
      S_PULSE:  leds_next = 6'b000010;
      S_GAP:    leds_next = 6'b000100;
      S_ACQ:    leds_next = 6'b001000;
      S_REPDLY: leds_next = 6'b010000;
      S_DONE:   leds_next = 6'b100000;
      default:  leds_next = 6'd0;
    endcase
  end

  // start_q resets high so a start level held through reset is not mistaken for an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      start_q_reg   <= 1'b1;
      pos_reg       <= '0;
      cnt_reg       <= '0;
      scan_reg      <= '0;
      aborted_reg   <= 1'b0;
      npulse_reg    <= '0;
      freq_reg      <= '0;
      acq_len_reg   <= '0;
      rep_dly_reg   <= '0;
      nscan_reg     <= '0;
      en_gen_reg    <= 1'b0;
      acq_en_reg    <= 1'b0;
      acq_rst_n_reg <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      leds_reg      <= '0;
      sts_reg       <= '0;
      amp_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      start_q_reg   <= start_i;
      pos_reg       <= pos_next;
      cnt_reg       <= cnt_next;
      scan_reg      <= scan_next;
      aborted_reg   <= aborted_next;
      if (latch_cfg) begin
        npulse_reg  <= (cfg_npulse_i > NPW'(NPULSE)) ? NPW'(NPULSE) : cfg_npulse_i;
        freq_reg    <= cfg_freq_i;
        acq_len_reg <= cfg_acq_len_i;
        rep_dly_reg <= cfg_rep_dly_i;
        nscan_reg   <= cfg_nscan_i;
      end
      en_gen_reg    <= (state_next == S_PULSE);
      acq_en_reg    <= (state_next == S_ACQ);
      acq_rst_n_reg <= (state_next != S_LOAD);
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      leds_reg      <= leds_next;
      sts_reg       <= sts_next;
      amp_reg       <= amp_next;
    end
  end

`ifdef NMR_SEQ_PHASE_CYCLE_EN
  logic [1:0] phase_reg;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         phase_reg <= 2'd0;
    else if (latch_cfg) phase_reg <= 2'd0;
    else if (scan_adv)  phase_reg <= phase_reg + 2'd1;
  end
  assign phase_o = phase_reg;
`else
  assign phase_o = 2'd0;
`endif

  assign en_gen_o    = en_gen_reg;
  assign amp_o       = amp_reg;
  assign freq_o      = freq_reg;
  assign acq_rst_n_o = acq_rst_n_reg;
  assign acq_en_o    = acq_en_reg;
  assign scan_o      = scan_reg;
  assign busy_o      = busy_reg;
  assign done_o      = done_reg;
  assign leds_o      = leds_reg;
  assign sts_o       = sts_reg;

endmodule

// File: tb/tb_nmr_pulse_sequencer.sv
// Scoreboard bench for nmr_pulse_sequencer: expected output segments are queued per scenario
// and compared cycle by cycle on the falling edge.
module tb_nmr_pulse_sequencer;
  localparam int NPULSE = 4;
  localparam int CW     = 32;
  localparam int SW     = 16;

  localparam logic [5:0] L_IDLE  = 6'b000000;
  localparam logic [5:0] L_LOAD  = 6'b000001;
  localparam logic [5:0] L_PULSE = 6'b000010;
  localparam logic [5:0] L_GAP   = 6'b000100;
  localparam logic [5:0] L_ACQ   = 6'b001000;
  localparam logic [5:0] L_REP   = 6'b010000;
  localparam logic [5:0] L_DONE  = 6'b100000;

  logic                clk;
  logic                rst_n;
  logic                start_i, abort_i;
  logic [2:0]          cfg_npulse_i;
  logic [NPULSE*CW-1:0] cfg_pulse_len_i, cfg_gap_len_i;
  logic [NPULSE*16-1:0] cfg_amp_i;
  logic [31:0]         cfg_freq_i;
  logic [CW-1:0]       cfg_acq_len_i, cfg_rep_dly_i;
  logic [SW-1:0]       cfg_nscan_i;
  logic                en_gen_o, acq_rst_n_o, acq_en_o, busy_o, done_o;
  logic [15:0]         amp_o;
  logic [31:0]         freq_o, sts_o;
  logic [1:0]          phase_o;
  logic [SW-1:0]       scan_o;
  logic [5:0]          leds_o;

  nmr_pulse_sequencer #(.NPULSE(NPULSE), .CW(CW), .SW(SW)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
    .cfg_npulse_i(cfg_npulse_i), .cfg_pulse_len_i(cfg_pulse_len_i),
    .cfg_gap_len_i(cfg_gap_len_i), .cfg_amp_i(cfg_amp_i), .cfg_freq_i(cfg_freq_i),
    .cfg_acq_len_i(cfg_acq_len_i), .cfg_rep_dly_i(cfg_rep_dly_i), .cfg_nscan_i(cfg_nscan_i),
    .en_gen_o(en_gen_o), .amp_o(amp_o), .freq_o(freq_o), .phase_o(phase_o),
    .acq_rst_n_o(acq_rst_n_o), .acq_en_o(acq_en_o), .scan_o(scan_o),
    .busy_o(busy_o), .done_o(done_o), .leds_o(leds_o), .sts_o(sts_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  leds;
    logic [15:0] amp;
    logic [15:0] scan;
    logic        arn;
    logic        aborted;
    logic [31:0] freq;
    int          len;
  } seg_t;

  seg_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  string       cur_tag = "init";
  logic [31:0] cur_freq = 32'd0;
  logic        cur_aborted = 1'b0;
  int          pl[4], gl[4], al[4];

  function automatic string seg_name(input logic [5:0] leds);
    case (leds)
      L_LOAD:  return "LOAD";
      L_PULSE: return "PULSE";
      L_GAP:   return "GAP";
      L_ACQ:   return "ACQ";
      L_REP:   return "REPDLY";
      L_DONE:  return "DONE";
      default: return "IDLE";
    endcase
  endfunction

  function automatic logic [108:0] exp_vec(input seg_t s);
    logic [2:0]  code;
    logic [1:0]  ph;
    logic        busy;
    logic        done;
    logic [31:0] sts;
    case (s.leds)
      L_LOAD:  code = 3'd1;
      L_PULSE: code = 3'd2;
      L_GAP:   code = 3'd3;
      L_ACQ:   code = 3'd4;
      L_REP:   code = 3'd5;
      L_DONE:  code = 3'd6;
      default: code = 3'd0;
    endcase
`ifdef NMR_SEQ_PHASE_CYCLE_EN
    ph = s.scan[1:0];
`else
    ph = 2'd0;
`endif
    busy = |s.leds[4:0];
    done = s.leds[5];
    sts  = {s.scan, 9'd0, code, 1'b0, s.aborted, busy, done};
    return {s.leds, (s.leds == L_PULSE), (s.leds == L_ACQ), s.arn, busy, done,
            s.amp, s.scan, ph, s.freq, sts};
  endfunction

  task automatic check(input logic [108:0] expv, input string what);
    logic [108:0] obs;
    obs = {leds_o, en_gen_o, acq_en_o, acq_rst_n_o, busy_o, done_o,
           amp_o, scan_o, phase_o, freq_o, sts_o};
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s/%s: observed=%h expected=%h", cur_tag, what, obs, expv);
    end
  endtask

  task automatic push(input logic [5:0] leds, input logic [15:0] amp,
                      input logic [15:0] scan, input int len);
    seg_t s;
    s.leds    = leds;
    s.amp     = amp;
    s.scan    = scan;
    s.arn     = (leds != L_LOAD);
    s.aborted = cur_aborted;
    s.freq    = cur_freq;
    s.len     = len;
    sb.push_back(s);
  endtask

  task automatic set_cfg(input int np, input logic [31:0] f, input int acq,
                         input int rep, input int ns);
    cfg_npulse_i = 3'(np);
    for (int i = 0; i < NPULSE; i++) begin
      cfg_pulse_len_i[i*CW +: CW] = CW'(pl[i]);
      cfg_gap_len_i[i*CW +: CW]   = CW'(gl[i]);
      cfg_amp_i[i*16 +: 16]       = 16'(al[i]);
    end
    cfg_freq_i    = f;
    cfg_acq_len_i = CW'(acq);
    cfg_rep_dly_i = CW'(rep);
    cfg_nscan_i   = SW'(ns);
    cur_freq      = f;
    cur_aborted   = 1'b0;
  endtask

  // Garbage on the config bus once LOAD has passed must not disturb the running sequence.
  task automatic scramble_cfg();
    cfg_npulse_i    = 3'($urandom);
    cfg_pulse_len_i = {$urandom, $urandom, $urandom, $urandom};
    cfg_gap_len_i   = {$urandom, $urandom, $urandom, $urandom};
    cfg_amp_i       = {$urandom, $urandom};
    cfg_freq_i      = $urandom;
    cfg_acq_len_i   = $urandom;
    cfg_rep_dly_i   = $urandom;
    cfg_nscan_i     = SW'($urandom);
  endtask

  task automatic run_sb(input bit scramble);
    seg_t s;
    int   idx;
    idx = 0;
    while (sb.size() != 0) begin
      s = sb.pop_front();
      for (int c = 0; c < s.len; c++) begin
        @(negedge clk);
        check(exp_vec(s), seg_name(s.leds));
        if (scramble && idx == 0) scramble_cfg();
        idx++;
      end
      $display("[TB] %s: %s x%0d checked", cur_tag, seg_name(s.leds), s.len);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0;
    pl = '{0, 0, 0, 0}; gl = '{0, 0, 0, 0}; al = '{0, 0, 0, 0};
    set_cfg(0, 32'd0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    cur_tag = "reset";
    check(109'd0, "reset_state");
    rst_n = 1'b1;
    push(L_IDLE, 16'h0, 16'd0, 2);
    run_sb(0);

    cur_tag = "single_pulse";
    pl = '{10, 0, 0, 0}; gl = '{5, 0, 0, 0}; al = '{16'h1234, 0, 0, 0};
    set_cfg(1, 32'hCAFE0001, 20, 0, 1);
    start_i = 1'b1;
    push(L_LOAD, 16'h0, 16'd0, 1);
    push(L_PULSE, 16'h1234, 16'd0, 10);
    push(L_GAP, 16'h0, 16'd0, 5);
    push(L_ACQ, 16'h0, 16'd0, 20);
    push(L_DONE, 16'h0, 16'd0, 3);
    run_sb(1);
    start_i = 1'b0;
    push(L_IDLE, 16'h0, 16'd0, 2);
    run_sb(0);

    cur_tag = "two_pulse";
    pl = '{4, 8, 0, 0}; gl = '{0, 3, 0, 0}; al = '{16'h1111, 16'h2222, 0, 0};
    set_cfg(2, 32'h00C0FFEE, 5, 0, 1);
    start_i = 1'b1;
    push(L_LOAD, 16'h0, 16'd0, 1);
    push(L_PULSE, 16'h1111, 16'd0, 4);
    push(L_PULSE, 16'h2222, 16'd0, 8);
    push(L_GAP, 16'h0, 16'd0, 3);
    push(L_ACQ, 16'h0, 16'd0, 5);
    push(L_DONE, 16'h0, 16'd0, 2);
    run_sb(1);
    start_i = 1'b0;
    push(L_IDLE, 16'h0, 16'd0, 1);
    run_sb(0);

    cur_tag = "multi_scan";
    pl = '{2, 0, 0, 0}; gl = '{1, 0, 0, 0}; al = '{16'hABCD, 0, 0, 0};
    set_cfg(1, 32'h12345678, 4, 7, 3);
    start_i = 1'b1;
    push(L_LOAD, 16'h0, 16'd0, 1);
    for (int s = 0; s < 3; s++) begin
      if (s > 0) push(L_REP, 16'h0, 16'(s), 7);
      push(L_PULSE, 16'hABCD, 16'(s), 2);
      push(L_GAP, 16'h0, 16'(s), 1);
      push(L_ACQ, 16'h0, 16'(s), 4);
    end
    push(L_DONE, 16'h0, 16'd2, 2);
    run_sb(1);
    start_i = 1'b0;
    push(L_IDLE, 16'h0, 16'd2, 1);
    run_sb(0);

    cur_tag = "clamp_skip";
    pl = '{1, 0, 2, 0}; gl = '{0, 1, 0, 0}; al = '{16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D};
    set_cfg(7, 32'hA5A5A5A5, 3, 0, 1);
    start_i = 1'b1;
    push(L_LOAD, 16'h0, 16'd0, 1);
    push(L_PULSE, 16'h0A0A, 16'd0, 1);
    push(L_GAP, 16'h0, 16'd0, 1);
    push(L_PULSE, 16'h0C0C, 16'd0, 2);
    push(L_ACQ, 16'h0, 16'd0, 3);
    push(L_DONE, 16'h0, 16'd0, 2);
    run_sb(1);
    start_i = 1'b0;
    push(L_IDLE, 16'h0, 16'd0, 1);
    run_sb(0);

    cur_tag = "minimal";
    pl = '{0, 0, 0, 0}; gl = '{0, 0, 0, 0}; al = '{0, 0, 0, 0};
    set_cfg(0, 32'h0000BEEF, 0, 0, 0);
    start_i = 1'b1;
    push(L_LOAD, 16'h0, 16'd0, 1);
    push(L_ACQ, 16'h0, 16'd0, 1);
    push(L_DONE, 16'h0, 16'd0, 2);
    run_sb(1);
    start_i = 1'b0;
    push(L_IDLE, 16'h0, 16'd0, 1);
    run_sb(0);

    cur_tag = "abort";
    pl = '{10, 0, 0, 0}; gl = '{2, 0, 0, 0}; al = '{16'h5555, 0, 0, 0};
    set_cfg(1, 32'hDEAD0006, 5, 0, 1);
    start_i = 1'b1;
    push(L_LOAD, 16'h0, 16'd0, 1);
    push(L_PULSE, 16'h5555, 16'd0, 3);
    run_sb(1);
    abort_i = 1'b1;
    cur_aborted = 1'b1;
    push(L_IDLE, 16'h0, 16'd0, 1);
    run_sb(0);
    abort_i = 1'b0;
    push(L_IDLE, 16'h0, 16'd0, 2);
    run_sb(0);
    start_i = 1'b0;
    push(L_IDLE, 16'h0, 16'd0, 1);
    run_sb(0);

    cur_tag = "reset_mid_acq";
    pl = '{2, 0, 0, 0}; gl = '{1, 0, 0, 0}; al = '{16'h7777, 0, 0, 0};
    set_cfg(1, 32'hFEED0007, 5, 0, 1);
    start_i = 1'b1;
    push(L_LOAD, 16'h0, 16'd0, 1);
    push(L_PULSE, 16'h7777, 16'd0, 2);
    push(L_GAP, 16'h0, 16'd0, 1);
    push(L_ACQ, 16'h0, 16'd0, 2);
    run_sb(1);
    #2 rst_n = 1'b0;
    #1 check(109'd0, "async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    cur_freq = 32'd0;
    push(L_IDLE, 16'h0, 16'd0, 4);
    run_sb(0);
    start_i = 1'b0;
    push(L_IDLE, 16'h0, 16'd0, 1);
    run_sb(0);

    cur_tag = "restart";
    pl = '{0, 0, 0, 0}; gl = '{0, 0, 0, 0}; al = '{0, 0, 0, 0};
    set_cfg(0, 32'h00000808, 2, 0, 1);
    start_i = 1'b1;
    push(L_LOAD, 16'h0, 16'd0, 1);
    push(L_ACQ, 16'h0, 16'd0, 2);
    push(L_DONE, 16'h0, 16'd0, 2);
    run_sb(1);
    start_i = 1'b0;
    push(L_IDLE, 16'h0, 16'd0, 1);
    run_sb(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/nmr_pulse_sequencer.md
NMR_PULSE_SEQUENCER -- requirements
Module: nmr_pulse_sequencer

Interface
REQ-001 Parameters SHALL be:
- NPULSE, default 4: maximum number of pulses per scan.
- CW, default 32: width of the time counters.
- SW, default 16: width of the scan counter.
REQ-002 Ports SHALL be as follows (name, direction, width, meaning):
- clk, in, 1: the single clock.
- rst_n, in, 1: reset; asynchronous, active-low.
- start_i, in, 1: level request; a sequence starts on its rising edge.
- abort_i, in, 1: synchronous abort.
- cfg_npulse_i, in, clog2(NPULSE+1): number of pulses in use.
- cfg_pulse_len_i, in, NPULSE*CW: pulse k length in cycles, slice k.
- cfg_gap_len_i, in, NPULSE*CW: delay after pulse k in cycles.
- cfg_amp_i, in, NPULSE*16: amplitude for pulse k.
- cfg_freq_i, in, 32: generator frequency word.
- cfg_acq_len_i, in, CW: acquisition window in cycles.
- cfg_rep_dly_i, in, CW: delay between scans in cycles.
- cfg_nscan_i, in, SW: number of scans.
- en_gen_o, out, 1: generator enable.
- amp_o, out, 16: amplitude of the current pulse.
- freq_o, out, 32: latched frequency word.
- phase_o, out, 2: RF phase for the current scan.
- acq_rst_n_o, out, 1: writer/packetiser reset, active-low.
- acq_en_o, out, 1: acquisition window.
- scan_o, out, SW: index of the scan in progress.
- busy_o, out, 1: sequence running.
- done_o, out, 1: sequence complete.
- leds_o, out, 6: state display.
- sts_o, out, 32: status word.

Function
REQ-003 States SHALL be IDLE, LOAD, PULSE, GAP, ACQ, REPDLY and DONE, and the FSM SHALL be registered.
REQ-004 IDLE SHALL go to LOAD on a start_i rising edge (start_i registered once; level 0 then 1).
REQ-005 LOAD SHALL last 1 cycle:
- latch all cfg_* inputs into internal registers; later changes to cfg_* SHALL have no effect until the next LOAD;
- assert acq_rst_n_o=0;
- clear the pulse index k and scan_o.
REQ-006 PULSE k SHALL last exactly pulse_len[k] cycles with en_gen_o=1 and amp_o=amp[k]. A zero length SHALL skip the PULSE state in 0 cycles.
REQ-007 GAP k SHALL last gap_len[k] cycles with en_gen_o=0. A zero length SHALL skip the state. After the GAP, k increments; when k reaches npulse the FSM goes to ACQ, otherwise to PULSE k+1.
REQ-008 npulse=0 SHALL go directly from LOAD/REPDLY to ACQ. npulse>NPULSE SHALL be clamped to NPULSE.
REQ-009 ACQ SHALL last max(acq_len,1) cycles with acq_en_o=1.
REQ-010 At the end of ACQ:
- if scan_o+1 >= max(nscan,1), go to DONE;
- otherwise increment scan_o, reset k to 0, and enter REPDLY for rep_dly cycles (0 skips REPDLY), then PULSE 0.
REQ-011 DONE SHALL hold done_o=1 and busy_o=0 until start_i=0, then return to IDLE.
REQ-012 busy_o SHALL be 1 in every state from LOAD through REPDLY.
REQ-013 abort_i=1 in any non-IDLE state SHALL force IDLE on the next edge:
- en_gen_o and acq_en_o SHALL be 0 from that edge;
- sts_o[2] SHALL be set.
REQ-014 abort_i SHALL take priority over every other transition.
REQ-015 Time counters SHALL count down from the loaded length to 1. The counter wrap SHALL never be observable.
REQ-016 Outputs SHALL be registered, and every output change SHALL occur on the same edge as the state change.
REQ-017 sts_o SHALL report:
- [0] = done;
- [1] = busy;
- [2] = aborted (sticky until the next LOAD);
- [6:4] = state code;
- [31:16] = scan_o (zero-extended or truncated).
REQ-018 leds_o SHALL be one-hot by state: LOAD=bit0, PULSE=bit1, GAP=bit2, ACQ=bit3, REPDLY=bit4, DONE=bit5. IDLE SHALL drive 0.

Reset
REQ-019 rst_n=0 SHALL asynchronously force:
- state to IDLE;
- all counters and latched configuration to 0;
- en_gen_o, acq_en_o, busy_o, done_o, leds_o, sts_o, amp_o, freq_o, phase_o and scan_o to 0;
- acq_rst_n_o to 0.
REQ-020 In IDLE out of reset, acq_rst_n_o SHALL be 1. A reset mid-sequence SHALL require a new start_i rising edge before a sequence runs.

Configuration
REQ-021 With NMR_SEQ_PHASE_CYCLE_EN defined, phase_o SHALL be 0 at LOAD and SHALL increment modulo 4 at each REPDLY entry.
REQ-022 Without NMR_SEQ_PHASE_CYCLE_EN, phase_o SHALL be constant 0 and no phase logic SHALL be synthesised.

Verification
REQ-023 npulse=1, len0=10, gap0=5, acq=20, nscan=1, start -> en_gen_o high for exactly 10 cycles, then 5 low, acq_en_o high for 20 cycles, done_o=1 and sts_o[0]=1.
REQ-024 npulse=2, len={4,8}, gap={0,3} -> en_gen_o 4 high, 8 high (contiguous, no gap), 3 low, then ACQ; amp_o switches amp0 to amp1 at cycle 4.
REQ-025 nscan=3, rep_dly=7 -> three ACQ windows separated by 7 idle cycles; scan_o runs 0,1,2; with the macro, phase_o runs 0,1,2.
REQ-026 abort_i pulse at cycle 3 of PULSE -> en_gen_o=0 on the next edge, state IDLE, sts_o[2]=1, done_o=0.
REQ-027 npulse=0, acq_len=0, nscan=0 -> LOAD, 1-cycle ACQ, DONE.
REQ-028 rst_n low mid-ACQ -> all outputs 0 asynchronously; after release, no activity until a new start_i rising edge.
